register_file: RTL and testbench
================================

# register_file

Sixteen-entry, 32-bit general register file that receives the write-back interface driven by pipeline stage 2: full-word memory-load writes and the four immediate-load forms. It also serves two registered read ports to the decode/ALU stage. A per-register pending scoreboard lets the issue stage claim a destination when a load is launched and stall dependants until the write-back lands. Read ports forward same-cycle write-back data.

## Interface

Parameters:
- none; depth fixed at 16, width fixed at 32.

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clock
- write_index  in  4  destination register for write-back
- write  in  1  full-word write of write_data this cycle
- write_data  in  32  word from memory load
- write_immediate  in  1  immediate write this cycle
- write_immediate_data  in  16  immediate payload
- write_immediate_type  in  2  t_immediate_type: 0 IT_UNSIGNED, 1 IT_SIGNED, 2 IT_TOPHALF, 3 IT_BOTTOMHALF
- claim  in  1  issue stage marks claim_index pending
- claim_index  in  4  register being claimed
- read_left_index  in  4  left read port address
- read_right_index  in  4  right read port address
- read_left_data  out  32  registered left read data
- read_right_data  out  32  registered right read data
- left_pending  out  1  combinational: pending[read_left_index]
- right_pending  out  1  combinational: pending[read_right_index]
- stall  out  1  combinational: left_pending | right_pending

## Operation

- Write-back value (next_value) when write=1: write_data.
- When write=0, write_immediate=1, by type:
  - IT_UNSIGNED: {16'h0, imm}.
  - IT_SIGNED: {{16{imm[15]}}, imm}.
  - IT_TOPHALF: {imm, reg[write_index][15:0]}.
  - IT_BOTTOMHALF: {reg[write_index][31:16], imm}.
- write and write_immediate both high: write wins; immediate ignored.
- Any write-back (write or write_immediate) updates reg[write_index] and clears pending[write_index].
- claim=1 sets pending[claim_index].
  - Claim and write-back to the same index in the same cycle: pending ends set, because the new claim is newer. Register data is still updated.
- Read ports: each cycle, read_x_data <= (write-back active and write_index == read_x_index) ? next_value : reg[read_x_index].
  - Forwarding applies to both ports independently, including both ports on the same index.
  - IT_TOPHALF/IT_BOTTOMHALF forwarding merges with the pre-write register contents.
- No hardwired zero register; r0 is an ordinary register.
- Reset: all 16 registers 0, all pending bits 0, read_left_data = read_right_data = 0. Reset overrides simultaneous write/claim.

## Timing

- Write-back: value visible in the register array the cycle after the edge on which write/write_immediate is sampled.
- Read latency: 1 cycle, address at edge N → data valid after edge N, including forwarded data.
- pending/stall: combinational from the current pending array and indices.
  - Claim at edge N raises stall from edge N onward for readers of that index.
  - Write-back at edge M drops it after edge M, unless re-claimed at M.
- Reset asserted mid-operation: after the reset edge every output is 0 and all pending bits are clear. The first write after reset deassertion behaves normally.
- Outstanding claims are lost on reset; the issue stage must also be reset.

## Test plan

- Reset, then read r0..r15 on both ports → all read 32'h0; stall=0.
- Immediate forms on r3, then read r3:
  - IT_UNSIGNED 16'h8001 → 32'h00008001.
  - IT_SIGNED 16'h8001 → 32'hFFFF8001.
  - IT_TOPHALF 16'h1234 → 32'h1234_8001.
  - IT_BOTTOMHALF 16'hBEEF → 32'h1234_BEEF.
- Forwarding: write=1, write_index=5, write_data=32'hDEADBEEF, with both read indices=5 in the same cycle → both read_data = 32'hDEADBEEF the next cycle.
- Scoreboard: claim r7.
  - read_left_index=7 → stall=1.
  - Write r7 with 32'h55 → stall=0 after that edge; read r7 = 32'h55.
  - Claim and write r7 in the same cycle → stall stays 1.
- Priority: write=1 (32'hA5A5A5A5) and write_immediate=1 (IT_UNSIGNED, 16'h1111) to r9 → r9 = 32'hA5A5A5A5.
- Reset mid-operation: load r2=32'hCAFEF00D, claim r4, assert reset with a simultaneous write to r2 → r2 reads 0 and stall=0 on r4.

Source files
------------

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module   : register_file
// Purpose  : 16 x 32-bit register file with immediate write-back forms,
//            pending-load scoreboard and forwarding registered read ports.
// Revision : 1.0
// ============================================================================
module register_file (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  write_index,
  input  logic        write,
  input  logic [31:0] write_data,
  input  logic        write_immediate,
  input  logic [15:0] write_immediate_data,
  input  logic [1:0]  write_immediate_type,
  input  logic        claim,
  input  logic [3:0]  claim_index,
  input  logic [3:0]  read_left_index,
  input  logic [3:0]  read_right_index,
  output logic [31:0] read_left_data,
  output logic [31:0] read_right_data,
  output logic        left_pending,
  output logic        right_pending,
  output logic        stall
);

  localparam logic [1:0] c_IT_UNSIGNED   = 2'd0;
  localparam logic [1:0] c_IT_SIGNED     = 2'd1;
  localparam logic [1:0] c_IT_TOPHALF    = 2'd2;
  localparam logic [1:0] c_IT_BOTTOMHALF = 2'd3;

  logic [31:0] r_regs [0:15];
  logic [15:0] r_pending;
  logic [15:0] w_pending_next;
  logic [31:0] w_current;
  logic [31:0] w_next_value;
  logic        w_writeback;

  // Half-word immediates merge with the pre-write contents of the destination.
  always_comb begin
    w_current    = r_regs[write_index];
    w_writeback  = write | write_immediate;
    w_next_value = write_data;
    if (!write) begin
      case (write_immediate_type)
        c_IT_UNSIGNED:   w_next_value = {16'h0000, write_immediate_data};
        c_IT_SIGNED:     w_next_value = {{16{write_immediate_data[15]}}, write_immediate_data};
        c_IT_TOPHALF:    w_next_value = {write_immediate_data, w_current[15:0]};
        c_IT_BOTTOMHALF: w_next_value = {w_current[31:16], write_immediate_data};
      endcase
    end
  end

  // Claim is applied after the write-back clear so a same-cycle re-claim wins.
  always_comb begin
    w_pending_next = r_pending;
    if (w_writeback) w_pending_next[write_index] = 1'b0;
    if (claim)       w_pending_next[claim_index] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
      r_pending       <= '0;
      read_left_data  <= '0;
      read_right_data <= '0;
    end else begin
      if (w_writeback) r_regs[write_index] <= w_next_value;
      r_pending       <= w_pending_next;
      read_left_data  <= (w_writeback && (write_index == read_left_index))
                         ? w_next_value : r_regs[read_left_index];
      read_right_data <= (w_writeback && (write_index == read_right_index))
                         ? w_next_value : r_regs[read_right_index];
    end
  end

  assign left_pending  = r_pending[read_left_index];
  assign right_pending = r_pending[read_right_index];
  assign stall         = left_pending | right_pending;

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_file
// Purpose  : Scoreboard bench for register_file against an array-based model.
// Revision : 1.0
// ============================================================================
module tb_register_file;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  write_index;
  logic        write;
  logic [31:0] write_data;
  logic        write_immediate;
  logic [15:0] write_immediate_data;
  logic [1:0]  write_immediate_type;
  logic        claim;
  logic [3:0]  claim_index;
  logic [3:0]  read_left_index;
  logic [3:0]  read_right_index;
  logic [31:0] read_left_data;
  logic [31:0] read_right_data;
  logic        left_pending;
  logic        right_pending;
  logic        stall;

  register_file dut (
    .clock                (clock),
    .reset                (reset),
    .write_index          (write_index),
    .write                (write),
    .write_data           (write_data),
    .write_immediate      (write_immediate),
    .write_immediate_data (write_immediate_data),
    .write_immediate_type (write_immediate_type),
    .claim                (claim),
    .claim_index          (claim_index),
    .read_left_index      (read_left_index),
    .read_right_index     (read_right_index),
    .read_left_data       (read_left_data),
    .read_right_data      (read_right_data),
    .left_pending         (left_pending),
    .right_pending        (right_pending),
    .stall                (stall)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] left;
    logic [31:0] right;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_regs [16];
  logic [15:0] m_pend;
  int          total = 0;
  int          bad   = 0;
  bit          armed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_value(input logic [31:0] old);
    logic [31:0] v;
    if (write) return write_data;
    case (write_immediate_type)
      2'd0: v = 32'(write_immediate_data);
      2'd1: v = 32'(signed'(write_immediate_data));
      2'd2: v = (32'(write_immediate_data) << 16) + (old % 32'h10000);
      default: v = (old / 32'h10000) * 32'h10000 + 32'(write_immediate_data);
    endcase
    return v;
  endfunction

  // One clock edge: update the reference model and queue the expected reads.
  task automatic tick();
    exp_t        e;
    logic [31:0] nv;
    bit          wb;
    @(posedge clock);
    if (reset) begin
      e.left = 0; e.right = 0;
      foreach (m_regs[i]) m_regs[i] = 0;
      m_pend = 0;
    end else begin
      wb = write || write_immediate;
      nv = model_value(m_regs[write_index]);
      e.left  = (wb && write_index == read_left_index)  ? nv : m_regs[read_left_index];
      e.right = (wb && write_index == read_right_index) ? nv : m_regs[read_right_index];
      if (wb) begin
        m_regs[write_index] = nv;
        m_pend[write_index] = 1'b0;
      end
      if (claim) m_pend[claim_index] = 1'b1;
    end
    q.push_back(e);
    armed = 1;
    #1;
  endtask

  task automatic idle();
    reset = 0; write = 0; write_immediate = 0; claim = 0;
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (armed) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("read_left_data", read_left_data, e.left);
        chk("read_right_data", read_right_data, e.right);
      end
      chk("left_pending", 32'(left_pending), 32'(m_pend[read_left_index]));
      chk("right_pending", 32'(right_pending), 32'(m_pend[read_right_index]));
      chk("stall", 32'(stall), 32'(m_pend[read_left_index] | m_pend[read_right_index]));
    end
  end

  initial begin
    idle();
    reset = 1;
    write_index = 0; write_data = 0; write_immediate_data = 0;
    write_immediate_type = 0; claim_index = 0;
    read_left_index = 0; read_right_index = 0;
    m_pend = 0;
    tick();
    reset = 0;

    // Reset contents: sweep all registers on both ports.
    for (int i = 0; i < 16; i++) begin
      read_left_index = 4'(i); read_right_index = 4'(15 - i);
      tick();
    end
    #3 chk("reset_stall", 32'(stall), 32'h0);

    // Immediate forms on r3, forwarded on the left port.
    write_index = 3; read_left_index = 3; write_immediate = 1;
    write_immediate_type = 0; write_immediate_data = 16'h8001; tick();
    #3 chk("imm_unsigned", read_left_data, 32'h0000_8001);
    write_immediate_type = 1; tick();
    #3 chk("imm_signed", read_left_data, 32'hFFFF_8001);
    write_immediate_type = 2; write_immediate_data = 16'h1234; tick();
    #3 chk("imm_tophalf", read_left_data, 32'h1234_8001);
    write_immediate_type = 3; write_immediate_data = 16'hBEEF; tick();
    #3 chk("imm_bottomhalf", read_left_data, 32'h1234_BEEF);
    idle(); tick();
    #3 chk("imm_readback", read_left_data, 32'h1234_BEEF);

    // Forwarding to both ports on the same index.
    write = 1; write_index = 5; write_data = 32'hDEADBEEF;
    read_left_index = 5; read_right_index = 5; tick();
    #3 chk("fwd_left", read_left_data, 32'hDEADBEEF);
    chk("fwd_right", read_right_data, 32'hDEADBEEF);
    idle();

    // Scoreboard on r7.
    read_right_index = 0;
    claim = 1; claim_index = 7; read_left_index = 7; tick();
    claim = 0;
    #3 chk("claim_stall", 32'(stall), 32'h1);
    write = 1; write_index = 7; write_data = 32'h55; tick();
    write = 0;
    #3 chk("wb_clears_stall", 32'(stall), 32'h0);
    chk("wb_r7", read_left_data, 32'h55);
    claim = 1; write = 1; write_data = 32'h66; tick();
    idle();
    #3 chk("reclaim_stall", 32'(stall), 32'h1);
    write = 1; write_data = 32'h77; tick();
    idle();

    // write beats write_immediate.
    write = 1; write_immediate = 1; write_immediate_type = 0;
    write_index = 9; write_data = 32'hA5A5A5A5; write_immediate_data = 16'h1111;
    read_left_index = 9; tick();
    idle(); tick();
    #3 chk("priority_r9", read_left_data, 32'hA5A5A5A5);

    // Reset mid-operation.
    write = 1; write_index = 2; write_data = 32'hCAFEF00D; tick();
    idle(); claim = 1; claim_index = 4; tick();
    idle(); reset = 1; write = 1; write_index = 2; write_data = 32'h12345678;
    read_left_index = 2; read_right_index = 4; tick();
    idle();
    #3 chk("reset_read", read_left_data, 32'h0);
    chk("reset_stall_r4", 32'(stall), 32'h0);
    tick();
    #3 chk("reset_r2", read_left_data, 32'h0);

    // Randomized traffic with occasional reset.
    for (int n = 0; n < 600; n++) begin
      reset                = ($urandom_range(0, 99) < 2);
      write                = ($urandom_range(0, 3) == 0);
      write_immediate      = ($urandom_range(0, 9) < 3);
      write_index          = 4'($urandom_range(0, 15));
      write_data           = $urandom;
      write_immediate_data = 16'($urandom_range(0, 65535));
      write_immediate_type = 2'($urandom_range(0, 3));
      claim                = ($urandom_range(0, 4) == 0);
      claim_index          = 4'($urandom_range(0, 15));
      read_left_index      = 4'($urandom_range(0, 15));
      read_right_index     = ($urandom_range(0, 3) == 0) ? read_left_index
                                                         : 4'($urandom_range(0, 15));
      tick();
    end
    idle();

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clock);
    chk("queue_drained", 32'(q.size()), 32'h0);
    @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
